// File: rtl/ones_count_pkg.sv
// Shared types and saturating-add helpers for the per-frame ones-count accumulator.
package ones_count_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } oc_state_t;

    // Operands are carried at this width; callers must keep w <= SAT_MAX_W.
    localparam int SAT_MAX_W = 32;

    function automatic logic [SAT_MAX_W:0] sat_limit(input int w);
        return ((SAT_MAX_W + 1)'(1) << w) - (SAT_MAX_W + 1)'(1);
    endfunction

    function automatic logic sat_ovf(input logic [SAT_MAX_W-1:0] a,
                                     input logic [SAT_MAX_W-1:0] b,
                                     input int w);
        logic [SAT_MAX_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum > sat_limit(w);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                     input logic [SAT_MAX_W-1:0] b,
                                                     input int w);
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = sat_limit(w);
        return (sum > lim) ? lim[SAT_MAX_W-1:0] : sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/ones_counter.sv
// Combinational population count of one beat; generalises the three-input lab counter.
module ones_counter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CNT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/ones_count_acc.sv
// Per-frame ones-count accumulator with valid/ready input and registered frame result.
//   state | meaning
//   IDLE  | no frame open, accumulator empty
//   ACCUM | frame open, summing beats until in_last
//   HOLD  | frame total presented on out_valid, waiting for out_ready
module ones_count_acc
    import ones_count_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] out_count_o,
    output logic             out_sat_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    oc_state_t        state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] res_q, res_d;
    logic             res_sat_q, res_sat_d;

    logic [CNT_W-1:0] beat_cnt;
    logic             accept;
    logic [ACC_W-1:0] base_acc;
    logic             base_sat;
    logic [ACC_W-1:0] sum_val;
    logic             sum_sat;

    ones_counter #(.WIDTH(WIDTH)) u_ones_counter (
        .data_i  (in_data_i),
        .count_o (beat_cnt)
    );

    assign accept = in_valid_i && in_ready_o && !clear_i;

    // A beat taken in IDLE or HOLD seeds a fresh frame, so only ACCUM carries history.
    assign base_acc = (state_q == ACCUM) ? acc_q : '0;
    assign base_sat = (state_q == ACCUM) && sat_q;
    assign sum_val  = ACC_W'(sat_add(SAT_MAX_W'(base_acc), SAT_MAX_W'(beat_cnt), ACC_W));
    assign sum_sat  = base_sat || sat_ovf(SAT_MAX_W'(base_acc), SAT_MAX_W'(beat_cnt), ACC_W);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) state_d = in_last_i ? HOLD : ACCUM;
                end
                ACCUM: begin
                    if (accept && in_last_i) state_d = HOLD;
                end
                HOLD: begin
                    if (out_ready_i) begin
                        if (accept) state_d = in_last_i ? HOLD : ACCUM;
                        else        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        case (state_q)
            ACCUM: busy_o = 1'b1;
            HOLD: begin
                in_ready_o  = out_ready_i;
                out_valid_o = 1'b1;
                busy_o      = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        acc_d     = acc_q;
        sat_d     = sat_q;
        res_d     = res_q;
        res_sat_d = res_sat_q;
        if (clear_i) begin
            acc_d     = '0;
            sat_d     = 1'b0;
            res_d     = '0;
            res_sat_d = 1'b0;
        end else if (accept) begin
            if (in_last_i) begin
                res_d     = sum_val;
                res_sat_d = sum_sat;
                acc_d     = '0;
                sat_d     = 1'b0;
            end else begin
                acc_d = sum_val;
                sat_d = sum_sat;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q     <= '0;
            sat_q     <= 1'b0;
            res_q     <= '0;
            res_sat_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            res_q     <= res_d;
            res_sat_q <= res_sat_d;
        end
    end

    assign out_count_o = res_q;
    assign out_sat_o   = res_sat_q;

endmodule

// File: doc/ones_count_acc.md
# ones_count_acc

Parametrised, clocked successor to the three-input ones-counter lab block. Each accepted beat of a WIDTH-bit word has its set bits counted. The counts are accumulated over a frame delimited by `in_last`, and the frame total is presented on a valid/ready output. It sits between a streaming bit-source and any consumer that needs per-frame population counts, such as a parity/weight checker.

## Interface
- `WIDTH`, 8: bits per input beat, ≥1.
- `ACC_W`, 16: accumulator/result width, ≥ $clog2(WIDTH+1).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous abort; empties all state.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat can be accepted.
- `in_data`  in  WIDTH  beat payload.
- `in_last`  in  1  final beat of frame; qualified by the input handshake.
- `out_valid`  out  1  frame result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_count`  out  ACC_W  frame total of set bits.
- `out_sat`  out  1  total clipped at 2^ACC_W−1.
- `busy`  out  1  high in ACCUM or HOLD.

## Operation
- Accept: `in_valid && in_ready` in a cycle.
- The beat count is popcount(`in_data`), width $clog2(WIDTH+1), zero-extended to ACC_W+1 before the add.
- FSM states are IDLE, ACCUM and HOLD.
  - IDLE: `acc`=0, `sat`=0. An accept without last goes to ACCUM with `acc`=count. An accept with last goes to HOLD with result=count.
  - ACCUM: each accept sets `acc`=sat_add(`acc`, count). With last, the result is loaded and the state goes to HOLD.
  - HOLD: `out_valid`=1. On `out_ready`, go to IDLE, or start the next frame if a beat is accepted the same cycle.
- sat_add: if the sum exceeds 2^ACC_W−1, the result is 2^ACC_W−1 and `sat` is set. `sat` is sticky until the frame result is consumed.
- `in_ready` is 1 in IDLE and ACCUM. In HOLD, `in_ready` = `out_ready`, so there is no bubble when the consumer keeps up.
- Simultaneous consume and accept in HOLD: the result is consumed and the new beat seeds a fresh frame (acc=count, sat from that beat only). If that beat has last, the state stays in HOLD with the new result.
- `out_count`/`out_sat` are stable while `out_valid`=1 and `out_ready`=0.
- A zero-valued beat still counts as a beat; a frame of all zeros yields `out_count`=0.
- `clear`: the next state is IDLE, `acc`=0 and `out_valid`=0, regardless of handshakes that cycle. A beat offered with `clear` is dropped.
- Priority: `rst_n` low > `clear` > handshakes.

## Timing
- Reset (async assert, sync-released by the system) sets the state to IDLE.
- Output reset values: `out_valid`=0, `out_count`=0, `out_sat`=0, `busy`=0, `in_ready`=1. `in_ready` is combinational from state and `out_ready` and is high out of reset.
- Latency: the result appears on `out_valid` in the cycle after the last beat is accepted.
- Throughput: one beat per clock. In HOLD with `out_ready` held high, back-to-back single-beat frames give one result per clock.
- Reset asserted mid-frame or in HOLD: the result is lost, all outputs return to reset values immediately, and there is no partial output.
- `out_*` are registered. `in_ready` is the only combinational output path (`out_ready` → `in_ready`).

## Structure
- Package `ones_count_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ACCUM, HOLD} oc_state_t`;
  - function `sat_add`, parametrised by width.
- Sub-module `ones_counter #(WIDTH)` is a purely combinational popcount adder tree, `count` = number of ones in `data`. It is the generalisation of the three-input lab counter and can be verified standalone.
- Top holds the FSM, accumulator, saturation flag and output registers.

## Test plan
- Single-beat frame, WIDTH=8: `in_data`=8'b1011_0001 with last → next cycle `out_valid`=1, `out_count`=4, `out_sat`=0.
- 3-beat frame 8'hFF, 8'h00, 8'h0F (last) with `out_ready`=1 → `out_count`=12, one cycle after the third accept. `busy` is high from beat 1 to the consume.
- Backpressure: hold `out_ready`=0 for 5 cycles after a result → `in_ready`=0 and `out_count` stable. Then raise `out_ready` with a new last beat 8'h03 → the old result is consumed and the next cycle shows `out_count`=2.
- Saturation with ACC_W=4: frame 8'hFF, 8'hFF (last) → `out_count`=15, `out_sat`=1. The next frame 8'h01 (last) → `out_count`=1, `out_sat`=0.
- Abort: assert `clear` mid-frame after 8'hFF, then send 8'h01 (last) → `out_count`=1.
- Async reset: drop `rst_n` between clock edges while in HOLD → all outputs go to reset values before the next edge, and there is no result after release.
